mdio_slave: RTL and testbench

MDIO management responder (Clause 22) for the PHY side of the management link. Oversamples MDC/MDIO in the local `clk` domain and decodes preamble, start, opcode, PHY address, register address, turnaround and data. Write frames go to a register-bank port. Read frames fetch data from that port and drive it back onto the shared `eth_mdio` line. It pairs with the existing `mdio_dri` master in loopback benches and in FPGA-hosted PHY emulation.

---
 rtl/mdio_slave.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave.sv
// mdio_slave: Clause 22 MDIO management responder (PHY side).
// MDC/MDIO are oversampled in the clk domain; frames are decoded on MDC
// rising edges ("rticks") and mapped onto a simple register-bank port.
// Optional feature macro: MDIO_SLV_BCAST_EN (accept PHY address 0 for writes).
module mdio_slave #(
  parameter logic [4:0] PHY_ADDR = 5'b00100,
  parameter int         PRE_LEN  = 32,
  parameter int         TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eth_mdc,
  inout  wire         eth_mdio,
  output logic [4:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  // REGAD, TA and data bits still to come after a PHY address miss
  localparam logic [4:0]      SKIP_LAST = 5'd22;

  typedef enum logic [3:0] {
    IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP
  } state_t;

  state_t           state;
  logic [5:0]       ones_cnt;
  logic [4:0]       bit_cnt;
  logic [15:0]      shreg;
  logic             is_read;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mdio_oe;
  logic             mdio_out;
  logic             rd_dly_p0;
  logic             rd_dly_p1;

  logic mdc_p0, mdc_p1, mdc_p2;
  logic mdio_p0, mdio_p1;
  logic rtick;
  logic bit_s;

  logic [4:0] addr_rx;
  logic       addr_hit;

  // Saturating increment for the preamble ones counter
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  assign eth_mdio = mdio_oe ? mdio_out : 1'bz;

  // Address field as completed by the bit sampled on this rtick
  assign addr_rx = {shreg[3:0], bit_s};

`ifdef MDIO_SLV_BCAST_EN
  // Broadcast address 0 is honoured for writes only, so a read never drives the line
  assign addr_hit = (addr_rx == PHY_ADDR) || ((addr_rx == 5'd0) && !is_read);
`else
  assign addr_hit = (addr_rx == PHY_ADDR);
`endif

  // Synchronize MDC/MDIO and register the MDC rise as a one-cycle rtick with its data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_p0  <= 1'b0;
      mdc_p1  <= 1'b0;
      mdc_p2  <= 1'b0;
      mdio_p0 <= 1'b1;
      mdio_p1 <= 1'b1;
      rtick   <= 1'b0;
      bit_s   <= 1'b1;
    end else begin
      // stage p0/p1: two-flop synchronizers
      mdc_p0  <= eth_mdc;
      mdc_p1  <= mdc_p0;
      mdio_p0 <= eth_mdio;
      mdio_p1 <= mdio_p0;
      // stage p2: edge detect, rtick lands 3 cycles after the raw MDC rise
      mdc_p2  <= mdc_p1;
      rtick   <= mdc_p1 & ~mdc_p2;
      bit_s   <= mdio_p1;
    end
  end

  // Frame decoder: acts only on rticks, plus the inactivity timeout and read-data load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      is_read     <= 1'b0;
      tmo_cnt     <= '0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      mdio_oe     <= 1'b0;
      mdio_out    <= 1'b1;
      rd_dly_p0   <= 1'b0;
      rd_dly_p1   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      rd_dly_p0 <= reg_rd_en;
      rd_dly_p1 <= rd_dly_p0;

      if (busy && !rtick) begin
        if (tmo_cnt == TMO_LAST) begin
          // MDC has gone quiet mid-frame: abort and free the line
          state     <= IDLE;
          busy      <= 1'b0;
          ones_cnt  <= '0;
          mdio_oe   <= 1'b0;
          mdio_out  <= 1'b1;
          frame_err <= 1'b1;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else if (rtick) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (bit_s) begin
              ones_cnt <= sat_inc(ones_cnt);
            end else if (int'(ones_cnt) >= PRE_LEN) begin
              state <= START;
              busy  <= 1'b1;
            end else begin
              ones_cnt <= '0;
            end
          end
          START: begin
            if (bit_s) begin
              state   <= OP;
              bit_cnt <= '0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              ones_cnt  <= '0;
              frame_err <= 1'b1;
            end
          end
          OP: begin
            if (bit_cnt == 5'd0) begin
              shreg[0] <= bit_s;
              bit_cnt  <= 5'd1;
            end else begin
              bit_cnt <= '0;
              case ({shreg[0], bit_s})
                2'b10: begin is_read <= 1'b1; state <= PHYAD; end
                2'b01: begin is_read <= 1'b0; state <= PHYAD; end
                default: begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  ones_cnt  <= '0;
                  frame_err <= 1'b1;
                end
              endcase
            end
          end
          PHYAD: begin
            shreg <= {shreg[14:0], bit_s};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              // A miss is a frame for another PHY, not an error
              state   <= addr_hit ? REGAD : SKIP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          REGAD: begin
            shreg <= {shreg[14:0], bit_s};
            if (bit_cnt == 5'd4) begin
              bit_cnt   <= '0;
              reg_addr  <= addr_rx;
              reg_rd_en <= is_read;
              state     <= TA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TA: begin
            if (is_read) begin
              // Released through the first TA bit; drive the TA zero for the second
              mdio_oe  <= 1'b1;
              mdio_out <= 1'b0;
              bit_cnt  <= '0;
              state    <= RDATA;
            end else if ((bit_cnt == 5'd0) && bit_s) begin
              bit_cnt <= 5'd1;
            end else if ((bit_cnt == 5'd1) && !bit_s) begin
              bit_cnt <= '0;
              state   <= WDATA;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              ones_cnt  <= '0;
              frame_err <= 1'b1;
            end
          end
          WDATA: begin
            shreg <= {shreg[14:0], bit_s};
            if (bit_cnt == 5'd15) begin
              reg_wr_data <= {shreg[14:0], bit_s};
              reg_wr_en   <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
              ones_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          RDATA: begin
            if (bit_cnt == 5'd16) begin
              // D0 has been on the line for a full bit time
              mdio_oe  <= 1'b0;
              mdio_out <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              ones_cnt <= '0;
            end else begin
              mdio_out <= shreg[15];
              shreg    <= {shreg[14:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          SKIP: begin
            if (bit_cnt == SKIP_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              ones_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            ones_cnt <= '0;
          end
        endcase
      end

      // Read data is fetched well before the next rtick, so no shift can collide
      if (rd_dly_p1) begin
        shreg <= reg_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: directed, table-driven bench for mdio_slave.
// Acts as the MDIO master (MDC = clk/10) and watches the register-bank port.
module tb_mdio_slave;

  logic        clk;
  logic        rst_n;
  logic        eth_mdc;
  wire         eth_mdio;
  logic [4:0]  reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        busy;
  logic        frame_err;

  logic        tb_oe;
  logic        tb_out;

  int checks = 0;
  int errors = 0;

  // Monitor counters, written only by the monitor
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          err_cnt = 0;
  int          oe_cyc = 0;
  int          busy_cyc = 0;
  int          both_cnt = 0;
  logic [4:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

`ifdef MDIO_SLV_BCAST_EN
  localparam int BC = 1;
`else
  localparam int BC = 0;
`endif

  assign eth_mdio = tb_oe ? tb_out : 1'bz;

  mdio_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eth_mdc    (eth_mdc),
    .eth_mdio   (eth_mdio),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wr_data;
    end
    if (reg_rd_en) rd_cnt++;
    if (frame_err) err_cnt++;
    if (dut.mdio_oe) oe_cyc++;
    if (busy) busy_cyc++;
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [1:0]  ta;
    logic [15:0] wd;
    logic [15:0] rdd;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic        exp_drv;
    logic        exp_busy;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One MDC bit: data changes at the fall, master samples just before the rise
  task automatic mdc_bit(input logic drv, input logic b, output logic smp);
    eth_mdc = 1'b0;
    tb_oe   = drv;
    tb_out  = b;
    repeat (5) @(negedge clk);
    smp     = eth_mdio;
    eth_mdc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic idle_bits();
    logic s;
    mdc_bit(1'b1, 1'b0, s);
    mdc_bit(1'b1, 1'b0, s);
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                            input int ndata, output logic [15:0] rd, output logic ta2);
    logic s;
    logic drv;
    drv = (op != 2'b10);
    rd  = '0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, 1'b0, s);
    mdc_bit(1'b1, 1'b1, s);
    for (int i = 1; i >= 0; i--) mdc_bit(1'b1, op[i], s);
    for (int i = 4; i >= 0; i--) mdc_bit(1'b1, phy[i], s);
    for (int i = 4; i >= 0; i--) mdc_bit(1'b1, ra[i], s);
    mdc_bit(drv, ta[1], s);
    mdc_bit(drv, ta[0], ta2);
    for (int i = 0; i < ndata; i++) begin
      mdc_bit(drv, wd[15-i], s);
      rd[15-i] = s;
    end
  endtask

  initial begin
    logic [15:0] got;
    logic        ta2;
    int          w0, r0, e0, o0, b0;

    //        pre  op     phy     ra     ta     wd        rdd       wr rd err drv  busy
    vecs[0] = '{32, 2'b01, 5'h04, 5'h04, 2'b10, 16'hA5C3, 16'h0000, 1, 0, 0, 1'b0, 1'b1};
    vecs[1] = '{32, 2'b10, 5'h04, 5'h02, 2'b00, 16'h0000, 16'h1234, 0, 1, 0, 1'b1, 1'b1};
    vecs[2] = '{32, 2'b10, 5'h03, 5'h02, 2'b00, 16'h0000, 16'h5555, 0, 0, 0, 1'b0, 1'b1};
    vecs[3] = '{32, 2'b01, 5'h04, 5'h1F, 2'b10, 16'hFFFF, 16'h0000, 1, 0, 0, 1'b0, 1'b1};
    vecs[4] = '{31, 2'b01, 5'h04, 5'h06, 2'b10, 16'h00F0, 16'h0000, 0, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{32, 2'b11, 5'h04, 5'h06, 2'b10, 16'h0000, 16'h0000, 0, 0, 1, 1'b0, 1'b1};
    vecs[6] = '{32, 2'b01, 5'h04, 5'h06, 2'b11, 16'h0000, 16'h0000, 0, 0, 1, 1'b0, 1'b1};
    vecs[7] = '{32, 2'b10, 5'h04, 5'h1F, 2'b00, 16'h0000, 16'h8001, 0, 1, 0, 1'b1, 1'b1};
    vecs[8] = '{32, 2'b01, 5'h00, 5'h09, 2'b10, 16'h3C3C, 16'h0000, BC, 0, 0, 1'b0, 1'b1};
    vecs[9] = '{32, 2'b10, 5'h00, 5'h09, 2'b00, 16'h0000, 16'hFFFF, 0, 0, 0, 1'b0, 1'b1};

    rst_n       = 1'b0;
    eth_mdc     = 1'b0;
    tb_oe       = 1'b1;
    tb_out      = 1'b1;
    reg_rd_data = 16'h0000;
    repeat (4) @(negedge clk);

    chk("rst_reg_addr", 32'(reg_addr), 32'h0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'h0);
    chk("rst_wr_data", 32'(reg_wr_data), 32'h0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_mdio_oe", 32'(dut.mdio_oe), 32'h0);
    chk("rst_mdio_out", 32'(dut.mdio_out), 32'h1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cyc; b0 = busy_cyc;
      reg_rd_data = vecs[v].rdd;
      send_frame(vecs[v].pre, vecs[v].op, vecs[v].phy, vecs[v].ra, vecs[v].ta,
                 vecs[v].wd, 16, got, ta2);
      idle_bits();
      chk($sformatf("v%0d_wr_pulses", v), 32'(wr_cnt - w0), 32'(vecs[v].exp_wr));
      chk($sformatf("v%0d_rd_pulses", v), 32'(rd_cnt - r0), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_frame_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_line_driven", v), 32'(oe_cyc > o0), 32'(vecs[v].exp_drv));
      chk($sformatf("v%0d_busy_seen", v), 32'(busy_cyc > b0), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
      chk($sformatf("v%0d_oe_end", v), 32'(dut.mdio_oe), 32'h0);
      if (vecs[v].exp_wr != 0) begin
        chk($sformatf("v%0d_wr_addr", v), 32'(last_wr_addr), 32'(vecs[v].ra));
        chk($sformatf("v%0d_wr_data", v), 32'(last_wr_data), 32'(vecs[v].wd));
      end
      if (vecs[v].exp_rd != 0) begin
        chk($sformatf("v%0d_ta2", v), 32'(ta2), 32'h0);
        chk($sformatf("v%0d_rd_data", v), 32'(got), 32'(vecs[v].rdd));
        chk($sformatf("v%0d_reg_addr", v), 32'(reg_addr), 32'(vecs[v].ra));
      end
    end

    // MDC stops after 10 data bits of a read
    e0 = err_cnt;
    reg_rd_data = 16'hBEEF;
    send_frame(32, 2'b10, 5'h04, 5'h02, 2'b00, 16'h0000, 10, got, ta2);
    chk("tmo_partial_data", 32'(got[15:6]), 32'(10'(16'hBEEF >> 6)));
    chk("tmo_oe_before", 32'(dut.mdio_oe), 32'h1);
    repeat (1000) @(negedge clk);
    chk("tmo_err_early", 32'(err_cnt - e0), 32'h0);
    chk("tmo_busy_early", 32'(busy), 32'h1);
    repeat (100) @(negedge clk);
    chk("tmo_err", 32'(err_cnt - e0), 32'h1);
    chk("tmo_oe", 32'(dut.mdio_oe), 32'h0);
    chk("tmo_busy", 32'(busy), 32'h0);
    idle_bits();

    // Reset during RDATA bit 7, then a normal write
    reg_rd_data = 16'hC6A9;
    send_frame(32, 2'b10, 5'h04, 5'h0A, 2'b00, 16'h0000, 8, got, ta2);
    eth_mdc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_oe_before", 32'(dut.mdio_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_oe", 32'(dut.mdio_oe), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_reg_addr", 32'(reg_addr), 32'h0);
    chk("rstmid_wr_data", 32'(reg_wr_data), 32'h0);
    chk("rstmid_mdio_out", 32'(dut.mdio_out), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(32, 2'b01, 5'h04, 5'h07, 2'b10, 16'h0F0F, 16, got, ta2);
    idle_bits();
    chk("post_rst_wr_pulses", 32'(wr_cnt - w0), 32'h1);
    chk("post_rst_wr_addr", 32'(last_wr_addr), 32'h07);
    chk("post_rst_wr_data", 32'(last_wr_data), 32'h0F0F);
    chk("post_rst_err", 32'(err_cnt - e0), 32'h0);

    chk("wr_rd_overlap", 32'(both_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
